gpio_irq: RTL and testbench
===========================

GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 Parameter NUM_IO, default 16: number of pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: depth of the input synchronizer, legal range 2..3.
REQ-003 Port clk, input, 1: clock; rst, input, 1: reset, synchronous, active-high.
REQ-004 Ports req_i input 1 (bus request) and we_i input 1 (write enable).
REQ-005 Ports addr_i input 32 (byte address, only [7:0] decoded), data_i input 32 (write data), data_o output 32 (read data).
REQ-006 Port ack_o, output, 1: bus acknowledge.
REQ-007 Port io_in, input, NUM_IO: raw asynchronous pin levels.
REQ-008 Port io_out, output, NUM_IO: pin drive values.
REQ-009 Port io_oe, output, NUM_IO: per-pin output enable; 1 = drive. Tri-state buffering is done outside this block.
REQ-010 Port irq_o, output, 1: interrupt request, registered, active-high.

Function
REQ-011 Register map (addr_i[7:0]):
- 0x00 DIR rw, 1 = output
- 0x04 OUT rw
- 0x08 IN ro, synchronized pins
- 0x0C IE rw
- 0x10 ITYPE rw, 0 = level, 1 = edge
- 0x14 IPOL rw; edge mode: 0 = rising, 1 = falling; level mode: 0 = high, 1 = low
- 0x18 IP: read pending, write-1-to-clear
- 0x1C OUT_SET wo, reads 0
- 0x20 OUT_CLR wo, reads 0
REQ-012 ack_o equals req_i combinationally; every access completes in one cycle with no wait states.
REQ-013 data_o is combinational from current register state while req_i=1 and we_i=0; otherwise data_o is 0.
REQ-014 Writes (req_i=1, we_i=1) take effect at the next rising clk edge.
REQ-015 Bits at and above NUM_IO read 0 and ignore writes.
REQ-016 Unmapped addresses read 0 and ignore writes.
REQ-017 OUT_SET write: OUT <= OUT | data_i. OUT_CLR write: OUT <= OUT & ~data_i.
REQ-018 io_out = OUT and io_oe = DIR, both driven directly from the registers.
REQ-019 Each io_in bit passes through a SYNC_STAGES flip-flop chain. IN reflects the chain output, so the latency from a pin change to IN is SYNC_STAGES cycles.
REQ-020 A per-bit prev register holds the previous synchronized value.
REQ-021 Edge events:
- rising = sync & ~prev
- falling = ~sync & prev
REQ-022 Level event = (sync XOR IPOL), evaluated every cycle.
REQ-023 IP[i] is set on the cycle after the selected event is seen on bit i, independent of IE[i].
REQ-024 A W1C write clears the targeted IP bits. If a set event and a W1C hit the same bit in the same cycle, set wins.
REQ-025 In level mode a cleared IP bit re-sets on the next cycle while the level condition persists.
REQ-026 Writing ITYPE or IPOL does not modify IP.
REQ-027 irq_o <= |(IP & IE), registered, so irq_o rises one cycle after the IP bit sets.
REQ-028 Warm-up: a counter suppresses edge events for SYNC_STAGES+1 cycles after rst deasserts, to prevent spurious edges from the reset-zero chain. Level events are not suppressed.
REQ-029 Edge detection operates on every pin regardless of DIR, so output pins read back through io_in.

Reset
REQ-030 When rst=1 at a clk edge, the following clear to 0: DIR, OUT, IE, ITYPE, IPOL, IP, the synchronizer chain, prev, and irq_o. The warm-up counter reloads.
REQ-031 While rst=1, io_oe=0 and io_out=0. ack_o still follows req_i combinationally, and data_o follows REQ-013.
REQ-032 rst asserted mid-transaction discards the write. Any pending interrupt is dropped, and irq_o is 0 on the cycle after the reset edge.

Verification
REQ-033 Write DIR=0x00FF then OUT=0x00A5 -> io_oe=0x00FF, io_out=0x00A5. Then OUT_SET 0x0F00 and OUT_CLR 0x0005 -> OUT reads 0x0FA0.
REQ-034 io_in[3] goes 0->1 with ITYPE[3]=1, IPOL[3]=0, IE[3]=1 -> IN[3]=1 after 2 cycles, IP[3]=1 one cycle later, irq_o=1 one cycle after that. W1C 0x8 to IP -> IP=0 and irq_o falls one cycle later.
REQ-035 Level-low on pin 5 (ITYPE=0, IPOL[5]=1, io_in[5]=0), W1C 0x20 every cycle -> IP[5] re-sets each cycle and irq_o stays 1. Drive io_in[5]=1 -> IP[5] stays 0 after the next W1C.
REQ-036 A falling edge on pin 2 arrives in the same cycle as a W1C 0x4 -> IP[2] remains 1.
REQ-037 NUM_IO=8: write 0xFFFFFFFF to DIR -> reads 0x000000FF. A read of 0x24 returns 0. io_in held at 0xFF through reset release with ITYPE=0xFF -> IP stays 0 through warm-up.
REQ-038 rst pulsed while IP=0x1 and irq_o=1 -> all registers read 0 and irq_o=0 on the cycle after the reset edge.

Source files
------------

// File: rtl/gpio_irq.sv
// GPIO block with per-pin direction/output registers, synchronized inputs and
// edge/level interrupt capture behind a single-cycle register bus.
module gpio_irq #(
  parameter int NUM_IO      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oe,
  output logic              irq_o
);

  localparam logic [7:0] ADDR_DIR     = 8'h00;
  localparam logic [7:0] ADDR_OUT     = 8'h04;
  localparam logic [7:0] ADDR_IN      = 8'h08;
  localparam logic [7:0] ADDR_IE      = 8'h0C;
  localparam logic [7:0] ADDR_ITYPE   = 8'h10;
  localparam logic [7:0] ADDR_IPOL    = 8'h14;
  localparam logic [7:0] ADDR_IP      = 8'h18;
  localparam logic [7:0] ADDR_OUT_SET = 8'h1C;
  localparam logic [7:0] ADDR_OUT_CLR = 8'h20;

  localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

  logic [NUM_IO-1:0] dir_reg;
  logic [NUM_IO-1:0] out_reg;
  logic [NUM_IO-1:0] ie_reg;
  logic [NUM_IO-1:0] itype_reg;
  logic [NUM_IO-1:0] ipol_reg;
  logic [NUM_IO-1:0] ip_reg;
  logic [NUM_IO-1:0] ip_next;
  logic [NUM_IO-1:0] prev_reg;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_reg;
  logic [2:0]        warm_reg;
  logic              irq_reg;

  logic [NUM_IO-1:0] sync_val;
  logic [NUM_IO-1:0] wdata;
  logic [NUM_IO-1:0] rise;
  logic [NUM_IO-1:0] fall;
  logic [NUM_IO-1:0] edge_evt;
  logic [NUM_IO-1:0] level_evt;
  logic [NUM_IO-1:0] set_evt;
  logic [NUM_IO-1:0] w1c_mask;
  logic              wr_en;
  logic              edge_enable;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign wr_en       = req_i & we_i;
  assign wdata       = data_i[NUM_IO-1:0];
  assign sync_val    = sync_reg[SYNC_STAGES-1];
  assign unused_bits = ^{addr_i[31:8], data_i >> NUM_IO};

  // Edges are masked until the synchronizer has refilled after reset.
  assign edge_enable = (warm_reg == 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_evt
      assign rise[gi]      = sync_val[gi] & ~prev_reg[gi];
      assign fall[gi]      = ~sync_val[gi] & prev_reg[gi];
      assign edge_evt[gi]  = ipol_reg[gi] ? fall[gi] : rise[gi];
      assign level_evt[gi] = sync_val[gi] ^ ipol_reg[gi];
      assign set_evt[gi]   = itype_reg[gi] ? (edge_evt[gi] & edge_enable) : level_evt[gi];
    end
  endgenerate

  // A set event in the same cycle as a W1C keeps the bit pending.
  always_comb begin
    w1c_mask = '0;
    if (wr_en && addr_i[7:0] == ADDR_IP) begin
      w1c_mask = wdata;
    end
    ip_next = (ip_reg & ~w1c_mask) | set_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_reg   <= '0;
      out_reg   <= '0;
      ie_reg    <= '0;
      itype_reg <= '0;
      ipol_reg  <= '0;
      ip_reg    <= '0;
      prev_reg  <= '0;
      sync_reg  <= '0;
      irq_reg   <= 1'b0;
      warm_reg  <= WARM_LOAD;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], io_in};
      end else begin
        sync_reg[0] <= io_in;
      end
      prev_reg <= sync_val;
      ip_reg   <= ip_next;
      irq_reg  <= |(ip_reg & ie_reg);
      if (warm_reg != 3'd0) begin
        warm_reg <= warm_reg - 3'd1;
      end
      if (wr_en) begin
        case (addr_i[7:0])
          ADDR_DIR:     dir_reg   <= wdata;
          ADDR_OUT:     out_reg   <= wdata;
          ADDR_IE:      ie_reg    <= wdata;
          ADDR_ITYPE:   itype_reg <= wdata;
          ADDR_IPOL:    ipol_reg  <= wdata;
          ADDR_OUT_SET: out_reg   <= out_reg | wdata;
          ADDR_OUT_CLR: out_reg   <= out_reg & ~wdata;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i[7:0])
      ADDR_DIR:   rd_val[NUM_IO-1:0] = dir_reg;
      ADDR_OUT:   rd_val[NUM_IO-1:0] = out_reg;
      ADDR_IN:    rd_val[NUM_IO-1:0] = sync_val;
      ADDR_IE:    rd_val[NUM_IO-1:0] = ie_reg;
      ADDR_ITYPE: rd_val[NUM_IO-1:0] = itype_reg;
      ADDR_IPOL:  rd_val[NUM_IO-1:0] = ipol_reg;
      ADDR_IP:    rd_val[NUM_IO-1:0] = ip_reg;
      default:    rd_val = '0;
    endcase
  end

  assign data_o = (req_i && !we_i) ? rd_val : 32'h0;
  assign ack_o  = req_i;
  // Pins are forced quiet for the whole reset assertion, not only after the edge.
  assign io_out = rst ? '0 : out_reg;
  assign io_oe  = rst ? '0 : dir_reg;
  assign irq_o  = irq_reg;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_gpio_irq;

  logic        clk;
  logic        rst, req, we, ack, irq;
  logic [31:0] addr, wdat, rdat;
  logic [15:0] io_in, io_out, io_oe;

  logic        rst2, req2, we2, ack2, irq2;
  logic [31:0] addr2, wdat2, rdat2;
  logic [7:0]  io_in2, io_out2, io_oe2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  gpio_irq #(.NUM_IO(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdat),
    .data_o(rdat), .ack_o(ack), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .irq_o(irq)
  );

  gpio_irq #(.NUM_IO(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst2), .req_i(req2), .we_i(we2), .addr_i(addr2), .data_i(wdat2),
    .data_o(rdat2), .ack_o(ack2), .io_in(io_in2), .io_out(io_out2), .io_oe(io_oe2),
    .irq_o(irq2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0x%08h expected=<queued value>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.val);
      end
      $display("check %-14s obs=0x%08h exp=0x%08h", e.tag, obs, e.val);
    end
  endtask

  task automatic obs_exp(input string tag, input logic [31:0] obs, input logic [31:0] val);
    sb_push(tag, val);
    sb_check(obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdat = d;
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdat = '0;
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] val);
    logic [31:0] d;
    sb_push(tag, val);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdat;
    req = 1'b0; addr = '0;
    sb_check(d);
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    req2 = 1'b1; we2 = 1'b1; addr2 = a; wdat2 = d;
    tick();
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdat2 = '0;
  endtask

  task automatic rd2_exp(input string tag, input logic [31:0] a, input logic [31:0] val);
    logic [31:0] d;
    sb_push(tag, val);
    req2 = 1'b1; we2 = 1'b0; addr2 = a;
    #1;
    d = rdat2;
    req2 = 1'b0; addr2 = '0;
    sb_check(d);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdat = '0; io_in = '0;
    rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdat2 = '0; io_in2 = 8'hFF;

    // Reset behaviour
    tick(); tick(); tick();
    req = 1'b1; we = 1'b0; addr = 32'h0;
    #1;
    obs_exp("rst_ack", {31'b0, ack}, 32'h1);
    obs_exp("rst_data", rdat, 32'h0);
    req = 1'b0;
    obs_exp("rst_ack_low", {31'b0, ack}, 32'h0);
    obs_exp("rst_io_oe", {16'b0, io_oe}, 32'h0);
    rst = 1'b0;
    rd_exp("init_dir", 32'h00, 32'h0);
    rd_exp("init_ip", 32'h18, 32'h0);
    obs_exp("init_irq", {31'b0, irq}, 32'h0);

    // Output registers, set/clear aliases, masking, unmapped space
    wr(32'h00, 32'h0000_00FF);
    wr(32'h04, 32'h0000_00A5);
    obs_exp("io_oe", {16'b0, io_oe}, 32'h0000_00FF);
    obs_exp("io_out", {16'b0, io_out}, 32'h0000_00A5);
    wr(32'h1C, 32'h0000_0F00);
    wr(32'h20, 32'h0000_0005);
    rd_exp("out_setclr", 32'h04, 32'h0000_0FA0);
    obs_exp("io_out2", {16'b0, io_out}, 32'h0000_0FA0);
    rd_exp("out_set_rd0", 32'h1C, 32'h0);
    rd_exp("out_clr_rd0", 32'h20, 32'h0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd_exp("dir_mask", 32'h00, 32'h0000_FFFF);
    wr(32'h24, 32'h1234_5678);
    rd_exp("unmapped", 32'h24, 32'h0);
    rd_exp("write_read0", 32'h00, 32'h0000_FFFF);

    // Rising edge on pin 3
    wr(32'h10, 32'h8);
    wr(32'h14, 32'h0);
    wr(32'h0C, 32'h8);
    io_in = 16'h0008;
    tick();
    rd_exp("in_lat1", 32'h08, 32'h0);
    tick();
    rd_exp("in_lat2", 32'h08, 32'h8);
    rd_exp("ip_not_yet", 32'h18, 32'h0);
    tick();
    rd_exp("ip3_set", 32'h18, 32'h8);
    obs_exp("irq_lag", {31'b0, irq}, 32'h0);
    tick();
    obs_exp("irq_rise", {31'b0, irq}, 32'h1);
    wr(32'h18, 32'h8);
    rd_exp("ip3_clr", 32'h18, 32'h0);
    obs_exp("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    obs_exp("irq_fall", {31'b0, irq}, 32'h0);

    // Level-low on pin 5 with repeated W1C
    wr(32'h14, 32'h20);
    wr(32'h0C, 32'h28);
    tick();
    rd_exp("lvl_ip", 32'h18, 32'h20);
    obs_exp("lvl_irq", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wr(32'h18, 32'h20);
      rd_exp("lvl_reset_ip", 32'h18, 32'h20);
      obs_exp("lvl_irq_stay", {31'b0, irq}, 32'h1);
    end
    io_in = 16'h0028;
    tick(); tick(); tick();
    wr(32'h18, 32'h20);
    rd_exp("lvl_gone_ip", 32'h18, 32'h0);
    tick();
    rd_exp("lvl_gone_ip2", 32'h18, 32'h0);
    obs_exp("lvl_gone_irq", {31'b0, irq}, 32'h0);

    // Falling edge on pin 2 coincident with W1C
    wr(32'h10, 32'h0C);
    wr(32'h14, 32'h24);
    io_in = 16'h002C;
    tick(); tick(); tick();
    rd_exp("fall_quiet", 32'h18, 32'h0);
    io_in = 16'h0028;
    tick(); tick();
    wr(32'h18, 32'h4);
    rd_exp("set_wins", 32'h18, 32'h4);
    wr(32'h18, 32'h4);
    rd_exp("fall_clr", 32'h18, 32'h0);
    obs_exp("fall_no_irq", {31'b0, irq}, 32'h0);

    // Reset while an interrupt is pending, with a write in flight
    wr(32'h10, 32'h0D);
    wr(32'h0C, 32'h29);
    io_in = 16'h0029;
    tick(); tick(); tick();
    rd_exp("pre_rst_ip", 32'h18, 32'h1);
    tick();
    obs_exp("pre_rst_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h04; wdat = 32'h0000_FFFF;
    #1;
    obs_exp("rst_io_out", {16'b0, io_out}, 32'h0);
    obs_exp("rst_io_oe2", {16'b0, io_oe}, 32'h0);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0; wdat = '0;
    obs_exp("post_rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    rd_exp("post_rst_in", 32'h08, 32'h0);
    rd_exp("post_rst_dir", 32'h00, 32'h0);
    rd_exp("post_rst_out", 32'h04, 32'h0);
    rd_exp("post_rst_ie", 32'h0C, 32'h0);
    rd_exp("post_rst_ityp", 32'h10, 32'h0);
    rd_exp("post_rst_ipol", 32'h14, 32'h0);
    rd_exp("post_rst_ip", 32'h18, 32'h0);

    // NUM_IO=8 instance: warm-up suppression and width masking
    tick();
    rst2 = 1'b0;
    wr2(32'h10, 32'hFF);
    for (int i = 0; i < 6; i++) begin
      rd2_exp("warm_ip", 32'h18, 32'h0);
      tick();
    end
    rd2_exp("n8_in", 32'h08, 32'h0000_00FF);
    wr2(32'h0C, 32'hFF);
    tick();
    obs_exp("n8_irq", {31'b0, irq2}, 32'h0);
    wr2(32'h00, 32'hFFFF_FFFF);
    rd2_exp("n8_dir_mask", 32'h00, 32'h0000_00FF);
    obs_exp("n8_io_oe", {24'b0, io_oe2}, 32'h0000_00FF);
    rd2_exp("n8_unmapped", 32'h24, 32'h0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
